// File: rtl/photon_pkg.sv
// Shared state encoding and helpers for the photon detector FSM family.
package photon_pkg;

  localparam int STATE_W = 3;

  typedef enum logic [STATE_W-1:0] {
    ST_IDLE   = 3'd0,
    ST_ARMED  = 3'd1,
    ST_WINDOW = 3'd2,
    ST_DETECT = 3'd3,
    ST_HOLD   = 3'd4
  } state_t;

  // Covers the full 2..32 channel range; callers narrow the result.
  function automatic logic [5:0] popcount(input logic [31:0] v);
    logic [5:0] c;
    c = '0;
    for (int i = 0; i < 32; i++) c = c + {5'd0, v[i]};
    return c;
  endfunction

endpackage

// File: rtl/photon_edge_det.sv
// Rising-edge detector for the detector lines; history starts all-ones so
// lines already high when reset releases never register as edges.
module photon_edge_det #(
  parameter int N_CH = 6
) (
  input  logic            clk,
  input  logic            rst,
  input  logic [N_CH-1:0] s,
  output logic [N_CH-1:0] rise
);

  logic [N_CH-1:0] s_q;

  always_ff @(posedge clk) begin
    if (rst) s_q <= '1;
    else     s_q <= s;
  end

  assign rise = s & ~s_q;

endmodule

// File: rtl/photon_fsm_n.sv
// N-channel photon FSM: single/coincidence triggering, actuator hold
// window and a saturating accepted-event counter.
module photon_fsm_n
  import photon_pkg::*;
#(
  parameter int N_CH      = 6,
  parameter int WIN       = 4,
  parameter int HOLD      = 8,
  parameter int MIN_COINC = 2,
  parameter int CNT_W     = 16
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               en,
  input  logic               mode,
  input  logic               cnt_clr,
  input  logic [N_CH-1:0]    S,
  output logic [N_CH-1:0]    A,
  output logic [STATE_W-1:0] state,
  output logic               event_valid,
  output logic [CNT_W-1:0]   count,
  output logic               sat
);

  localparam int PC_W = $clog2(N_CH + 1);
  localparam int WT_W = (WIN > 1) ? $clog2(WIN) : 1;
  localparam int HT_W = (HOLD > 1) ? $clog2(HOLD) : 1;
  localparam logic [PC_W-1:0] MINC    = PC_W'(MIN_COINC);
  localparam logic [WT_W-1:0] WIN_LD  = WT_W'(WIN - 1);
  localparam logic [HT_W-1:0] HOLD_LD = HT_W'(HOLD - 1);

  function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] c);
    return (&c) ? c : c + CNT_W'(1);
  endfunction

  state_t          st;
  logic [N_CH-1:0] rise;
  logic [N_CH-1:0] mask;
  logic [N_CH-1:0] merged;
  logic [PC_W-1:0] pc_rise;
  logic [PC_W-1:0] pc_merged;
  logic [WT_W-1:0] wtmr;
  logic [HT_W-1:0] htmr;
  logic            fire;

  photon_edge_det #(.N_CH(N_CH)) u_edge (
    .clk  (clk),
    .rst  (rst),
    .s    (S),
    .rise (rise)
  );

  // mask is always empty in ARMED, so merged doubles as the ARMED trigger mask
  always_comb begin
    merged    = mask | rise;
    pc_rise   = PC_W'(popcount(32'(rise)));
    pc_merged = PC_W'(popcount(32'(merged)));
    fire      = 1'b0;
    if (en) begin
      case (st)
        ST_ARMED:  fire = (rise != '0) && (!mode || pc_rise >= MINC);
        ST_WINDOW: fire = (pc_merged >= MINC);
        default:   fire = 1'b0;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      st          <= ST_IDLE;
      A           <= '0;
      event_valid <= 1'b0;
      count       <= '0;
      sat         <= 1'b0;
      mask        <= '0;
      wtmr        <= '0;
      htmr        <= '0;
    end else begin
      event_valid <= fire;
      if (!en) begin
        st   <= ST_IDLE;
        A    <= '0;
        mask <= '0;
        wtmr <= '0;
        htmr <= '0;
      end else if (fire) begin
        st   <= ST_DETECT;
        mask <= merged;
        A    <= merged;
      end else begin
        case (st)
          ST_IDLE: begin
            A  <= '0;
            st <= ST_ARMED;
          end
          ST_ARMED: begin
            if (rise != '0) begin
              mask <= rise;
              wtmr <= WIN_LD;
              st   <= ST_WINDOW;
            end
          end
          ST_WINDOW: begin
            if (wtmr == '0) begin
              mask <= '0;
              st   <= ST_ARMED;
            end else begin
              mask <= merged;
              wtmr <= wtmr - WT_W'(1);
            end
          end
          ST_DETECT: begin
            htmr  <= HOLD_LD;
            st    <= ST_HOLD;
            count <= sat_inc(count);
            if (&count) sat <= 1'b1;
          end
          ST_HOLD: begin
            if (htmr == '0) begin
              A    <= '0;
              mask <= '0;
              st   <= ST_ARMED;
            end else begin
              htmr <= htmr - HT_W'(1);
            end
          end
          default: begin
            A    <= '0;
            mask <= '0;
            st   <= ST_IDLE;
          end
        endcase
      end
      if (cnt_clr) begin
        count <= '0;
        sat   <= 1'b0;
      end
    end
  end

  assign state = st;

endmodule

// File: tb/tb_photon_fsm_n.sv
// Directed bench for photon_fsm_n: default build plus a CNT_W=2 build for saturation.
module tb_photon_fsm_n;

  logic        clk = 1'b0;
  logic        rst, en, mode, cnt_clr;
  logic [5:0]  S, A;
  logic [2:0]  state;
  logic        ev;
  logic [15:0] count;
  logic        sat;

  logic        rst2, en2, mode2, clr2;
  logic [5:0]  S2, A2;
  logic [2:0]  state2;
  logic        ev2;
  logic [1:0]  count2;
  logic        sat2;

  int         n_checks = 0;
  int         n_fail   = 0;
  logic [5:0] exp_q[$];

  always #5 clk = ~clk;

  photon_fsm_n #(.N_CH(6), .WIN(4), .HOLD(8), .MIN_COINC(2), .CNT_W(16)) dut (
    .clk(clk), .rst(rst), .en(en), .mode(mode), .cnt_clr(cnt_clr), .S(S),
    .A(A), .state(state), .event_valid(ev), .count(count), .sat(sat)
  );

  photon_fsm_n #(.N_CH(6), .WIN(4), .HOLD(8), .MIN_COINC(2), .CNT_W(2)) dut2 (
    .clk(clk), .rst(rst2), .en(en2), .mode(mode2), .cnt_clr(clr2), .S(S2),
    .A(A2), .state(state2), .event_valid(ev2), .count(count2), .sat(sat2)
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    n_checks++;
    assert (obs === expv) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, expv);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic wait_armed(input bit second, input string tag);
    int n;
    n = 0;
    while (((second ? state2 : state) != 3'd1) && n < 40) begin
      tick();
      n++;
    end
    check(tag, 32'(second ? state2 : state), 32'd1);
  endtask

  // Every event pulse of the main DUT must match the next queued actuator mask
  always @(negedge clk) begin
    if (ev === 1'b1) begin
      n_checks++;
      assert (exp_q.size() != 0) else begin
        n_fail++;
        $error("FAIL unexpected_event: A=%0h with no event pending", A);
      end
      if (exp_q.size() != 0) check("event_mask", 32'(A), 32'(exp_q.pop_front()));
    end
  end

  initial begin
    #200000;
    $display("FAIL global_timeout: simulation did not finish, required completion");
    $fatal(1, "timeout");
  end

  initial begin
    int hi;
    int win;
    rst = 1; en = 0; mode = 0; cnt_clr = 0; S = '0;
    rst2 = 1; en2 = 0; mode2 = 0; clr2 = 0; S2 = 6'b000001;
    repeat (3) tick();
    check("rst_state", 32'(state), 32'd0);
    check("rst_A", 32'(A), 32'd0);
    check("rst_ev", 32'(ev), 32'd0);
    check("rst_count", 32'(count), 32'd0);
    check("rst_sat", 32'(sat), 32'd0);

    rst = 0; en = 1;
    tick();
    check("arm", 32'(state), 32'd1);

    // single mode: one hit, A held HOLD+1 cycles
    S = 6'b001000; exp_q.push_back(6'b001000);
    tick();
    S = '0;
    check("t1_detect", 32'(state), 32'd3);
    check("t1_ev", 32'(ev), 32'd1);
    check("t1_A", 32'(A), 32'h08);
    hi = 1;
    for (int i = 0; i < 12; i++) begin
      tick();
      if (A == 6'b001000) hi++;
      else break;
    end
    check("t1_hold_len", 32'(hi), 32'd9);
    check("t1_back_armed", 32'(state), 32'd1);
    check("t1_count", 32'(count), 32'd1);

    // coincidence across the window
    mode = 1; S = 6'b000001; exp_q.push_back(6'b010001);
    tick();
    check("t2_window", 32'(state), 32'd2);
    tick();
    S = 6'b010001;
    tick();
    check("t2_detect", 32'(state), 32'd3);
    check("t2_A", 32'(A), 32'h11);
    S = '0;
    wait_armed(1'b0, "t2_rearm");
    check("t2_count", 32'(count), 32'd2);

    // lone hit times out
    S = 6'b000100;
    tick();
    S = '0;
    win = (state == 3'd2) ? 1 : 0;
    for (int i = 0; i < 10; i++) begin
      tick();
      if (state == 3'd2) win++;
      else break;
    end
    check("t3_window_len", 32'(win), 32'd4);
    check("t3_armed", 32'(state), 32'd1);
    check("t3_A", 32'(A), 32'd0);
    check("t3_count", 32'(count), 32'd2);

    // simultaneous pair goes straight to DETECT
    S = 6'b001010; exp_q.push_back(6'b001010);
    tick();
    S = '0;
    check("t4_direct", 32'(state), 32'd3);
    check("t4_A", 32'(A), 32'h0A);
    wait_armed(1'b0, "t4_rearm");
    check("t4_count", 32'(count), 32'd3);

    // edges ignored during HOLD, then en drop
    mode = 0; S = 6'b001000; exp_q.push_back(6'b001000);
    tick();
    S = '0;
    check("t5_detect", 32'(state), 32'd3);
    tick();
    S = 6'b100000;
    tick();
    check("t5_hold_state", 32'(state), 32'd4);
    check("t5_hold_A", 32'(A), 32'h08);
    tick();
    check("t5_hold_count", 32'(count), 32'd4);
    en = 0;
    tick();
    check("t5_idle", 32'(state), 32'd0);
    check("t5_idle_A", 32'(A), 32'd0);
    check("t5_count_kept", 32'(count), 32'd4);
    en = 1;
    tick();
    check("t5_rearm", 32'(state), 32'd1);
    tick();
    tick();
    check("t5_no_stale_edge", 32'(state), 32'd1);
    S = '0;

    // narrow counter: S2 held high across reset release
    rst2 = 0; en2 = 1;
    tick();
    check("t6_arm", 32'(state2), 32'd1);
    tick();
    tick();
    check("t6_release_state", 32'(state2), 32'd1);
    check("t6_release_ev", 32'(ev2), 32'd0);
    check("t6_release_count", 32'(count2), 32'd0);
    for (int e = 1; e <= 4; e++) begin
      S2 = '0;
      tick();
      S2 = 6'b000001;
      tick();
      check("t6_ev", 32'(ev2), 32'd1);
      wait_armed(1'b1, "t6_rearm");
      check("t6_count", 32'(count2), (e <= 3) ? 32'(e) : 32'd3);
      check("t6_sat", 32'(sat2), (e == 4) ? 32'd1 : 32'd0);
    end
    clr2 = 1;
    tick();
    clr2 = 0;
    check("t6_clr_count", 32'(count2), 32'd0);
    check("t6_clr_sat", 32'(sat2), 32'd0);

    S2 = '0;
    tick();
    S2 = 6'b000001;
    tick();
    check("t6_clrwin_ev", 32'(ev2), 32'd1);
    clr2 = 1;
    tick();
    clr2 = 0;
    check("t6_clr_beats_inc", 32'(count2), 32'd0);
    wait_armed(1'b1, "t6_clrwin_rearm");

    S2 = '0;
    tick();
    S2 = 6'b000001; en2 = 0;
    tick();
    check("t6_en_suppress_state", 32'(state2), 32'd0);
    check("t6_en_suppress_ev", 32'(ev2), 32'd0);
    check("t6_en_suppress_count", 32'(count2), 32'd0);

    tick();
    check("sb_drained", 32'(exp_q.size()), 32'd0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
